if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder/controller.
- Owns the architectural PC and computes the next PC from the controller's NPCOp, target fields and rs data.
- Fetches instructions from a variable-latency instruction memory over a req/ready + rvalid handshake.
- Holds the fetched word stable for decode until the core commits it.

---
 rtl/if_fetch_unit_pkg.sv | 28 ++
 rtl/if_fetch_unit_npc_calc.sv | 37 +++
 rtl/if_fetch_unit.sv | 137 +++++++++++++
 tb/tb_if_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared NPC codes, fetch FSM encoding and default addresses
//
// Purpose : types and constants shared by the fetch unit, its next-PC
//           calculator and the main controller (same NPC encoding).
// Contents: NPC_* select codes, fetch_state_e, DEFAULT_RESET_PC,
//           DEFAULT_EXC_VECTOR, branch_offset() helper.
package if_fetch_unit_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_REG    = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // Word offset of a branch: sign-extend imm16 and scale to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_npc_calc.sv
// rtl/if_fetch_unit_npc_calc.sv - combinational next-PC calculator
//
// Purpose : selects the next PC from the controller's npc_op.
// Ports   : pc_i      current PC
//           npc_op_i  PLUS4 / BRANCH / JUMP / REG select
//           imm16_i   branch offset (instr[15:0])
//           imm26_i   jump index (instr[25:0])
//           rs_data_i register target for jr/jalr
//           npc_o     next PC, unaligned values passed through unchanged
module npc_calc
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  npc_op_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] npc_o
);

    logic [31:0] pc_plus4;

    // All arithmetic wraps modulo 2^32.
    assign pc_plus4 = pc_i + 32'd4;

    always_comb begin
        npc_o = pc_plus4;
        unique case (npc_op_i)
            NPC_PLUS4:  npc_o = pc_plus4;
            NPC_BRANCH: npc_o = pc_plus4 + branch_offset(imm16_i);
            NPC_JUMP:   npc_o = {pc_plus4[31:28], imm26_i, 2'b00};
            NPC_REG:    npc_o = rs_data_i;
            default:    npc_o = pc_plus4;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with PC, next-PC select and IM handshake
//
// Purpose : owns the architectural PC, fetches from a variable-latency
//           instruction memory (req/ready, then rvalid) and holds the word
//           for decode until commit.
// Ports   : clk, rst (sync, active high)
//           npc_op, imm16, imm26, rs_data, commit  - from the controller
//           im_req, im_addr / im_ready, im_rvalid, im_rdata - instruction memory
//           instr, instr_valid, pc, pc_plus4       - to decode / write-back
//           fetch_exc                              - only with IF_ALIGN_CHK_EN
// Option  : IF_ALIGN_CHK_EN - misaligned next PC redirects to EXC_VECTOR and
//           pulses fetch_exc; otherwise npc[1:0] is cleared before loading.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  npc_op,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    input  logic        commit,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
`ifdef IF_ALIGN_CHK_EN
    output logic        fetch_exc,
`endif
    output logic [31:0] pc_plus4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  npc;
    logic [31:0]  npc_load;

    npc_calc u_npc_calc (
        .pc_i      (pc_q),
        .npc_op_i  (npc_op),
        .imm16_i   (imm16),
        .imm26_i   (imm26),
        .rs_data_i (rs_data),
        .npc_o     (npc)
    );

`ifdef IF_ALIGN_CHK_EN
    logic fetch_exc_q, fetch_exc_d;
    logic npc_misaligned;

    assign npc_misaligned = |npc[1:0];
    assign npc_load       = npc_misaligned ? EXC_VECTOR : npc;
    assign fetch_exc      = fetch_exc_q;
`else
    logic unused_exc_vector;

    // Without the alignment check a bad target is silently word-aligned.
    assign npc_load          = npc & ~32'd3;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        im_req        = 1'b0;
`ifdef IF_ALIGN_CHK_EN
        fetch_exc_d   = 1'b0;
`endif
        unique case (state_q)
            S_REQ: begin
                // pc does not move here, so im_addr stays stable while stalled.
                im_req = 1'b1;
                if (im_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (im_rvalid) begin
                    instr_d       = im_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (commit) begin
                    pc_d          = npc_load;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
`ifdef IF_ALIGN_CHK_EN
                    fetch_exc_d   = npc_misaligned;
`endif
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
`ifdef IF_ALIGN_CHK_EN
            fetch_exc_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
`ifdef IF_ALIGN_CHK_EN
            fetch_exc_q   <= fetch_exc_d;
`endif
        end
    end

    assign im_addr     = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  npc_op;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic        commit;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef IF_ALIGN_CHK_EN
    logic        fetch_exc;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .npc_op      (npc_op),
        .imm16       (imm16),
        .imm26       (imm26),
        .rs_data     (rs_data),
        .commit      (commit),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ready    (im_ready),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
`ifdef IF_ALIGN_CHK_EN
        .fetch_exc   (fetch_exc),
`endif
        .pc_plus4    (pc_plus4)
    );

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] model_pc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] op,
                                            input logic [15:0] i16, input logic [25:0] i26,
                                            input logic [31:0] rs);
        logic [31:0] p4;
        logic [31:0] raw;
        p4 = cur + 32'd4;
        case (op)
            2'b00:   raw = p4;
            2'b01:   raw = p4 + {{14{i16[15]}}, i16, 2'b00};
            2'b10:   raw = {p4[31:28], i26, 2'b00};
            default: raw = rs;
        endcase
`ifdef IF_ALIGN_CHK_EN
        if (raw[1:0] != 2'b00) raw = 32'h0000_4180;
`else
        raw[1:0] = 2'b00;
`endif
        return raw;
    endfunction

    // Entered at a negedge with the DUT in S_REQ for address model_pc.
    task automatic fetch(input logic [31:0] rdata, input int ready_wait,
                         input int rvalid_wait, input bit stray_rvalid);
        exp_addr_q.push_back(model_pc);
        exp_instr_q.push_back(rdata);
        for (int i = 0; i < ready_wait; i++) begin
            chk("stall_req", {31'd0, im_req}, 32'd1);
            chk("stall_addr", im_addr, model_pc);
            chk("stall_valid", {31'd0, instr_valid}, 32'd0);
            im_ready  = 1'b0;
            im_rvalid = stray_rvalid && (i == 0);
            im_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            im_rvalid = 1'b0;
        end
        chk("req", {31'd0, im_req}, 32'd1);
        chk("addr", im_addr, exp_addr_q.pop_front());
        im_ready = 1'b1;
        @(negedge clk);
        im_ready = 1'b0;
        chk("wait_req", {31'd0, im_req}, 32'd0);
`ifdef IF_ALIGN_CHK_EN
        chk("exc_clear", {31'd0, fetch_exc}, 32'd0);
`endif
        for (int i = 0; i < rvalid_wait; i++) begin
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        im_rvalid = 1'b1;
        im_rdata  = rdata;
        @(negedge clk);
        im_rvalid = 1'b0;
        im_rdata  = 32'h0;
        chk("instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, exp_instr_q.pop_front());
        chk("pc", pc, model_pc);
        chk("pc_plus4", pc_plus4, model_pc + 32'd4);
    endtask

    // Entered at a negedge with the DUT in S_HOLD.
    task automatic commit_op(input logic [1:0] op, input logic [15:0] i16,
                             input logic [25:0] i26, input logic [31:0] rs,
                             input logic [31:0] plan_addr, input bit plan_exc);
        logic [31:0] nxt;
        nxt     = ref_npc(model_pc, op, i16, i26, rs);
        npc_op  = op;
        imm16   = i16;
        imm26   = i26;
        rs_data = rs;
        commit  = 1'b1;
        @(negedge clk);
        commit  = 1'b0;
        npc_op  = 2'b11;
        rs_data = 32'hBAD0_0000;
        model_pc = nxt;
        chk("npc_model", im_addr, model_pc);
        chk("npc_plan", im_addr, plan_addr);
        chk("cmt_valid", {31'd0, instr_valid}, 32'd0);
`ifdef IF_ALIGN_CHK_EN
        chk("fetch_exc", {31'd0, fetch_exc}, {31'd0, plan_exc});
`else
        if (plan_exc) chk("exc_plan_addr", im_addr, plan_addr);
`endif
    endtask

    initial begin
        rst = 1'b1; npc_op = 2'b00; imm16 = '0; imm26 = '0; rs_data = '0;
        commit = 1'b0; im_ready = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_pc = 32'h0000_3000;
        chk("rst_req", {31'd0, im_req}, 32'd1);
        chk("rst_addr", im_addr, 32'h0000_3000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h0000_3004);
`ifdef IF_ALIGN_CHK_EN
        chk("rst_exc", {31'd0, fetch_exc}, 32'd0);
`endif
        fetch(32'h2008_0005, 0, 0, 1'b0);

        commit_op(2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_3004, 1'b0);
        fetch(32'h1111_0001, 3, 1, 1'b1);

        commit_op(2'b11, 16'h0, 26'h0, 32'h0000_3010, 32'h0000_3010, 1'b0);
        fetch(32'h1111_0002, 0, 0, 1'b0);
        commit_op(2'b01, 16'hFFFC, 26'h0, 32'h0, 32'h0000_3004, 1'b0);
        fetch(32'h1111_0003, 1, 0, 1'b0);

        commit_op(2'b11, 16'h0, 26'h0, 32'h0000_3010, 32'h0000_3010, 1'b0);
        fetch(32'h1111_0004, 0, 2, 1'b0);
        commit_op(2'b01, 16'h0003, 26'h0, 32'h0, 32'h0000_3020, 1'b0);
        fetch(32'h1111_0005, 0, 0, 1'b0);

        commit_op(2'b11, 16'h0, 26'h0, 32'h0000_3000, 32'h0000_3000, 1'b0);
        fetch(32'h1111_0006, 0, 0, 1'b0);
        commit_op(2'b10, 16'h0, 26'h0000C10, 32'h0, 32'h0000_3040, 1'b0);
        fetch(32'h1111_0007, 2, 0, 1'b0);
        commit_op(2'b11, 16'h0, 26'h0, 32'h0000_3100, 32'h0000_3100, 1'b0);
        fetch(32'h1111_0008, 0, 0, 1'b0);

        // PC wrap-around at the top of the address space.
        commit_op(2'b11, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        fetch(32'h1111_0009, 0, 0, 1'b0);
        chk("wrap_pc4", pc_plus4, 32'h0000_0000);
        commit_op(2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0000, 1'b0);
        fetch(32'h1111_000A, 0, 0, 1'b0);

        // Reset while waiting for data, with rvalid in the reset cycle.
        commit_op(2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0004, 1'b0);
        im_ready = 1'b1;
        @(negedge clk);
        im_ready = 1'b0;
        commit   = 1'b1;
        npc_op   = 2'b11;
        rs_data  = 32'h0000_5000;
        @(negedge clk);
        commit   = 1'b0;
        chk("wait_commit_req", {31'd0, im_req}, 32'd0);
        chk("wait_commit_pc", pc, 32'h0000_0004);
        chk("wait_commit_valid", {31'd0, instr_valid}, 32'd0);
        rst       = 1'b1;
        im_rvalid = 1'b1;
        im_rdata  = 32'hBADB_AD00;
        @(negedge clk);
        rst       = 1'b0;
        im_rvalid = 1'b0;
        model_pc  = 32'h0000_3000;
        chk("rstw_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstw_pc", pc, 32'h0000_3000);
        chk("rstw_req", {31'd0, im_req}, 32'd1);
        chk("rstw_instr", instr, 32'h0);
        fetch(32'h3C01_0001, 1, 2, 1'b0);

        // Misaligned register target.
`ifdef IF_ALIGN_CHK_EN
        commit_op(2'b11, 16'h0, 26'h0, 32'h0000_3102, 32'h0000_4180, 1'b1);
`else
        commit_op(2'b11, 16'h0, 26'h0, 32'h0000_3102, 32'h0000_3100, 1'b1);
`endif
        fetch(32'h1111_000B, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
